// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, packed writeback entry layout and register-file constants
package wb_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int FLAG_W     = 7;

    // Packed entry layout, MSB to LSB: {is_alu, dest, data, flags}
    localparam int WB_ENTRY_W = 1 + ADDR_W + DATA_W + FLAG_W;
    localparam int FLAGS_LSB  = 0;
    localparam int DATA_LSB   = FLAGS_LSB + FLAG_W;
    localparam int DEST_LSB   = DATA_LSB + DATA_W;
    localparam int IS_ALU_BIT = DEST_LSB + ADDR_W;

    // The register file only decodes the low five address bits
    localparam int RF_SEL_W   = 5;
    localparam logic [RF_SEL_W-1:0] FLAG_REG_ADDR = 5'd3;

    function automatic logic [WB_ENTRY_W-1:0] wb_pack(
        input logic              is_alu,
        input logic [ADDR_W-1:0] dest,
        input logic [DATA_W-1:0] data,
        input logic [FLAG_W-1:0] flags
    );
        return {is_alu, dest, data, flags};
    endfunction

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// rtl/regfile_writeback_unit_if.sv - writeback bus: ALU/load handshakes, register-file write port, control
// Optional WB_BYPASS_EN adds byp_addr/byp_hit/byp_data.
// master: producer/register-file side; slave: the writeback unit.
interface regfile_writeback_unit_if #(
    parameter int DEPTH = 4
) ();
    import wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic [FLAG_W-1:0] alu_flags;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_dest;
    logic [DATA_W-1:0] ld_data;
    logic              rf_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [FLAG_W-1:0] rf_flags;
    logic [CNT_W-1:0]  occupancy;
`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] byp_addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
`endif

    modport slave (
        input  flush, alu_valid, alu_dest, alu_data, alu_flags,
        input  ld_valid, ld_dest, ld_data, rf_stall,
`ifdef WB_BYPASS_EN
        input  byp_addr,
        output byp_hit, byp_data,
`endif
        output alu_ready, ld_ready, rf_we, rf_addr, rf_data, rf_flags, occupancy
    );

    modport master (
        output flush, alu_valid, alu_dest, alu_data, alu_flags,
        output ld_valid, ld_dest, ld_data, rf_stall,
`ifdef WB_BYPASS_EN
        output byp_addr,
        input  byp_hit, byp_data,
`endif
        input  alu_ready, ld_ready, rf_we, rf_addr, rf_data, rf_flags, occupancy
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO with push/pop/flush, full/empty/count
// Ports: clk, rst_n, flush_i, push_i, wdata_i, pop_i -> rdata_o, full_o, empty_o, count_o.
// With WB_BYPASS_EN the storage array and read pointer are exported for searching.
module wb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 24,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [W-1:0]            wdata_i,
    input  logic                    pop_i,
    output logic [W-1:0]            rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
`ifdef WB_BYPASS_EN
    output logic [DEPTH-1:0][W-1:0] entries_o,
    output logic [PTR_W-1:0]        rd_ptr_o,
`endif
    output logic [CNT_W-1:0]        count_o
);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q,  count_d;
    logic                    do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    // Flush wins over both operations so nothing slips in or out that cycle
    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
`ifdef WB_BYPASS_EN
    assign entries_o = mem_q;
    assign rd_ptr_o  = rd_ptr_q;
`endif

endmodule

// File: rtl/regfile_writeback_unit.sv
// rtl/regfile_writeback_unit.sv - queues ALU/load results and drains them as registered register-file writes
// Ports: clk, rst_n (async, active-low), wb (regfile_writeback_unit_if.slave: ALU and load
// handshakes, flush, rf_stall, registered rf_we/rf_addr/rf_data/rf_flags, occupancy).
// WB_BYPASS_EN: adds combinational byp_addr -> byp_hit/byp_data search of queued entries.
module regfile_writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    regfile_writeback_unit_if.slave   wb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  full, empty, push, pop;
    logic [WB_ENTRY_W-1:0] push_entry, head;
    logic [CNT_W-1:0]      count;

    logic                  rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0]     rf_addr_q,  rf_addr_d;
    logic [DATA_W-1:0]     rf_data_q,  rf_data_d;
    logic [FLAG_W-1:0]     rf_flags_q, rf_flags_d;
    logic [FLAG_W-1:0]     flag_q,     flag_d;

    logic                  head_is_alu;
    logic [FLAG_W-1:0]     head_flags;

`ifdef WB_BYPASS_EN
    logic [DEPTH-1:0][WB_ENTRY_W-1:0] entries;
    logic [PTR_W-1:0]                 rd_ptr;
`endif

    // Ready looks at full only, so a same-cycle pop never frees room for a push
    assign wb.ld_ready  = ~full & ~wb.flush;
    assign wb.alu_ready = ~full & ~wb.flush & ~wb.ld_valid;

    assign push       = (wb.ld_valid & wb.ld_ready) | (wb.alu_valid & wb.alu_ready);
    // Loads carry no flags; the held ALU flags are substituted when they drain
    assign push_entry = wb.ld_valid ? wb_pack(1'b0, wb.ld_dest, wb.ld_data, '0)
                                    : wb_pack(1'b1, wb.alu_dest, wb.alu_data, wb.alu_flags);
    assign pop        = ~empty & ~wb.rf_stall & ~wb.flush;

    wb_fifo #(.DEPTH(DEPTH), .W(WB_ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (wb.flush),
        .push_i    (push),
        .wdata_i   (push_entry),
        .pop_i     (pop),
        .rdata_o   (head),
        .full_o    (full),
        .empty_o   (empty),
`ifdef WB_BYPASS_EN
        .entries_o (entries),
        .rd_ptr_o  (rd_ptr),
`endif
        .count_o   (count)
    );

    assign head_is_alu = head[IS_ALU_BIT];
    assign head_flags  = head[FLAGS_LSB +: FLAG_W];

    always_comb begin
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        rf_flags_d = rf_flags_q;
        flag_d     = flag_q;
        if (pop) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = head[DEST_LSB +: ADDR_W];
            rf_data_d  = head[DATA_LSB +: DATA_W];
            // The flag register is written on every write, so loads re-write the held flags
            rf_flags_d = head_is_alu ? head_flags : flag_q;
            if (head_is_alu) flag_d = head_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            rf_flags_q <= '0;
            flag_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            rf_flags_q <= rf_flags_d;
            flag_q     <= flag_d;
        end
    end

    assign wb.rf_we     = rf_we_q;
    assign wb.rf_addr   = rf_addr_q;
    assign wb.rf_data   = rf_data_q;
    assign wb.rf_flags  = rf_flags_q;
    assign wb.occupancy = count;

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest; later matches overwrite earlier ones so the youngest wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        wb.byp_hit  = 1'b0;
        wb.byp_data = '0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (entries[idx][DEST_LSB +: RF_SEL_W] == wb.byp_addr[RF_SEL_W-1:0])) begin
                wb.byp_hit  = 1'b1;
                wb.byp_data = entries[idx][DATA_LSB +: DATA_W];
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb/tb_regfile_writeback_unit.sv - directed-vector bench for regfile_writeback_unit
module tb_regfile_writeback_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    regfile_writeback_unit_if #(.DEPTH(4)) bus ();

    regfile_writeback_unit #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [7:0] d, input logic [7:0] x, input logic [6:0] f);
        bus.alu_valid = v;
        bus.alu_dest  = d;
        bus.alu_data  = x;
        bus.alu_flags = f;
    endtask

    task automatic drive_ld(input logic v, input logic [7:0] d, input logic [7:0] x);
        bus.ld_valid = v;
        bus.ld_dest  = d;
        bus.ld_data  = x;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [7:0] a,
                            input logic [7:0] d, input logic [6:0] f);
        check({tag, "_we"},    32'(bus.rf_we),    32'(we));
        check({tag, "_addr"},  32'(bus.rf_addr),  32'(a));
        check({tag, "_data"},  32'(bus.rf_data),  32'(d));
        check({tag, "_flags"}, 32'(bus.rf_flags), 32'(f));
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.rf_stall = 1'b0;
        drive_alu(1'b0, 8'h00, 8'h00, 7'h00);
        drive_ld(1'b0, 8'h00, 8'h00);
`ifdef WB_BYPASS_EN
        bus.byp_addr = 8'h00;
`endif
        tick();
        tick();
        check_rf("reset", 1'b0, 8'h00, 8'h00, 7'h00);
        check("reset_occ", 32'(bus.occupancy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single ALU result: visible one edge after acceptance
        drive_alu(1'b1, 8'd5, 8'h3C, 7'h12);
        #1;
        check("alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        drive_alu(1'b0, 8'd0, 8'h00, 7'h00);
        check("alu_occ1", 32'(bus.occupancy), 32'd1);
        check("alu_we_early", 32'(bus.rf_we), 32'd0);
        tick();
        check_rf("alu", 1'b1, 8'd5, 8'h3C, 7'h12);
        check("alu_occ0", 32'(bus.occupancy), 32'd0);

        // Load keeps the previous ALU flags
        drive_ld(1'b1, 8'd7, 8'hA5);
        tick();
        drive_ld(1'b0, 8'd0, 8'h00);
        tick();
        check_rf("ld", 1'b1, 8'd7, 8'hA5, 7'h12);
        tick();
        check_rf("idle_hold", 1'b0, 8'd7, 8'hA5, 7'h12);

        // Load has priority over a simultaneous ALU offer
        drive_ld(1'b1, 8'd9, 8'h11);
        drive_alu(1'b1, 8'd10, 8'h22, 7'h05);
        #1;
        check("prio_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("prio_alu_ready", 32'(bus.alu_ready), 32'd0);
        tick();
        drive_ld(1'b0, 8'd0, 8'h00);
        #1;
        check("prio_alu_ready2", 32'(bus.alu_ready), 32'd1);
        tick();
        drive_alu(1'b0, 8'd0, 8'h00, 7'h00);
        check_rf("prio_first", 1'b1, 8'd9, 8'h11, 7'h12);
        check("pushpop_occ", 32'(bus.occupancy), 32'd1);
        tick();
        check_rf("prio_second", 1'b1, 8'd10, 8'h22, 7'h05);

        // Fill under stall: fifth offer refused
        bus.rf_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_alu(1'b1, 8'(16 + i), 8'(8'h40 + i), 7'(i));
            #1;
            check($sformatf("fill_ready%0d", i), 32'(bus.alu_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        drive_alu(1'b0, 8'd0, 8'h00, 7'h00);
        check("full_occ", 32'(bus.occupancy), 32'd4);
        check("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("stall_we", 32'(bus.rf_we), 32'd0);
        bus.rf_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_rf($sformatf("drain%0d", i), 1'b1, 8'(16 + i), 8'(8'h40 + i), 7'(i));
        end
        tick();
        check("drained_we", 32'(bus.rf_we), 32'd0);
        check("drained_occ", 32'(bus.occupancy), 32'd0);

        // Flush with three queued entries and a push on offer
        bus.rf_stall = 1'b1;
        drive_ld(1'b1, 8'd1, 8'hA1);
        tick();
        drive_ld(1'b1, 8'd2, 8'hA2);
        tick();
        drive_ld(1'b1, 8'd1, 8'hA3);
        tick();
        drive_ld(1'b0, 8'd0, 8'h00);
        check("flush_pre_occ", 32'(bus.occupancy), 32'd3);
`ifdef WB_BYPASS_EN
        bus.byp_addr = 8'd1;
        #1;
        check("byp_hit1", 32'(bus.byp_hit), 32'd1);
        check("byp_young", 32'(bus.byp_data), 32'hA3);
        bus.byp_addr = 8'h22;
        #1;
        check("byp_hit2", 32'(bus.byp_hit), 32'd1);
        check("byp_data2", 32'(bus.byp_data), 32'hA2);
        bus.byp_addr = 8'd4;
        #1;
        check("byp_miss", 32'(bus.byp_hit), 32'd0);
`endif
        bus.flush = 1'b1;
        drive_ld(1'b1, 8'd5, 8'h99);
        #1;
        check("flush_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("flush_alu_ready", 32'(bus.alu_ready), 32'd0);
        tick();
        bus.flush    = 1'b0;
        bus.rf_stall = 1'b0;
        drive_ld(1'b0, 8'd0, 8'h00);
        check("flush_occ", 32'(bus.occupancy), 32'd0);
        check("flush_we", 32'(bus.rf_we), 32'd0);
        tick();
        check("flush_we2", 32'(bus.rf_we), 32'd0);
        check("flush_occ2", 32'(bus.occupancy), 32'd0);
        drive_ld(1'b1, 8'd6, 8'h77);
        tick();
        drive_ld(1'b0, 8'd0, 8'h00);
        tick();
        check_rf("flag_kept", 1'b1, 8'd6, 8'h77, 7'h03);

        // Reset in the middle of a drain
        bus.rf_stall = 1'b1;
        drive_alu(1'b1, 8'd12, 8'h5A, 7'h7F);
        tick();
        drive_alu(1'b0, 8'd0, 8'h00, 7'h00);
        drive_ld(1'b1, 8'd13, 8'h5B);
        tick();
        drive_ld(1'b0, 8'd0, 8'h00);
        bus.rf_stall = 1'b0;
        tick();
        check_rf("middrain", 1'b1, 8'd12, 8'h5A, 7'h7F);
        rst_n = 1'b0;
        #1;
        check_rf("async_rst", 1'b0, 8'h00, 8'h00, 7'h00);
        check("async_rst_occ", 32'(bus.occupancy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_we", 32'(bus.rf_we), 32'd0);
        drive_ld(1'b1, 8'd2, 8'h33);
        tick();
        drive_ld(1'b0, 8'd0, 8'h00);
        tick();
        check_rf("flagq_reset", 1'b1, 8'd2, 8'h33, 7'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
